// File: rtl/alarm_pkg.sv
// Shared definitions for the alarm sequencer: state encoding, rest code and
// duration units used by both the player and the note ROM.
package alarm_pkg;

    typedef enum logic [1:0] {StIdle, StLoad, StPlay, StDone} state_e;

    localparam logic [19:0] NOTE_REST = 20'd1;

    localparam logic [4:0] QUARTER = 5'd2;
    localparam logic [4:0] HALF    = 5'd4;
    localparam logic [4:0] ONE     = 5'd8;

    // A zero-length step would never end, so it is stretched to one unit.
    function automatic logic [4:0] min_one(input logic [4:0] d);
        return (d == 5'd0) ? 5'd1 : d;
    endfunction

endpackage

// File: rtl/tone_gen.sv
// Square-wave generator: toggles every period/2 cycles while enabled,
// holds low for rest codes and whenever disabled.
module tone_gen
    import alarm_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic [19:0] period,
    output logic        speaker
);

    logic [18:0] half;
    logic [18:0] cnt_q, cnt_d;
    logic        spk_q, spk_d;

    assign half = period[19:1];

    always_comb begin
        cnt_d = '0;
        spk_d = 1'b0;
        if (en && (period > NOTE_REST)) begin
            if (cnt_q == half - 19'd1) begin
                cnt_d = '0;
                spk_d = ~spk_q;
            end else begin
                cnt_d = cnt_q + 19'd1;
                spk_d = spk_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
            spk_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            spk_q <= spk_d;
        end
    end

    assign speaker = spk_q;

endmodule

// File: rtl/alarm_player.sv
// Alarm sequencer: walks the note ROM, holds each step for its duration in
// ticks and drives the tone generator; wraps or pulses done at the end.
module alarm_player
    import alarm_pkg::*;
#(
    parameter int unsigned TICK_CYCLES = 12_500_000,
    parameter int unsigned LAST_INDEX  = 19,
    parameter bit          LOOP        = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        stop,
    input  logic [19:0] note,
    input  logic [4:0]  duration,
    output logic [5:0]  number,
    output logic        speaker,
    output logic        playing,
    output logic        done
);

    localparam int unsigned    TickW    = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [TickW-1:0] TickLast = TickW'(TICK_CYCLES - 1);
    localparam logic [5:0]     LastIdx  = 6'(LAST_INDEX);

    state_e             state_q, state_d;
    logic [19:0]        note_q, note_d;
    logic [4:0]         dur_q, dur_d;
    logic [4:0]         unit_q, unit_d;
    logic [TickW-1:0]   tick_q, tick_d;
    logic [5:0]         number_q, number_d;
    logic               playing_q, done_q;
    logic               step_end;
    logic               tone_en;

    assign step_end = (tick_q == TickLast) && (({1'b0, unit_q} + 6'd1) == {1'b0, dur_q});

    always_comb begin
        state_d  = state_q;
        note_d   = note_q;
        dur_d    = dur_q;
        tick_d   = tick_q;
        unit_d   = unit_q;
        number_d = number_q;
        if (stop) begin
            state_d  = StIdle;
            number_d = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    number_d = '0;
                    if (start) state_d = StLoad;
                end
                StLoad: begin
                    note_d  = note;
                    dur_d   = min_one(duration);
                    tick_d  = '0;
                    unit_d  = '0;
                    state_d = StPlay;
                end
                StPlay: begin
                    if (tick_q == TickLast) begin
                        tick_d = '0;
                        unit_d = unit_q + 5'd1;
                        if (step_end) begin
                            if (number_q != LastIdx) begin
                                number_d = number_q + 6'd1;
                                state_d  = StLoad;
                            end else if (LOOP) begin
                                number_d = '0;
                                state_d  = StLoad;
                            end else begin
                                number_d = '0;
                                state_d  = StDone;
                            end
                        end
                    end else begin
                        tick_d = tick_q + TickW'(1);
                    end
                end
                StDone: begin
                    number_d = '0;
                    state_d  = StIdle;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // Tone runs only on PLAY cycles that stay in PLAY, so it starts clean
    // after LOAD and is already silent in the cycle after a step ends or aborts.
    assign tone_en = (state_q == StPlay) && (state_d == StPlay);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            note_q    <= '0;
            dur_q     <= '0;
            tick_q    <= '0;
            unit_q    <= '0;
            number_q  <= '0;
            playing_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            note_q    <= note_d;
            dur_q     <= dur_d;
            tick_q    <= tick_d;
            unit_q    <= unit_d;
            number_q  <= number_d;
            playing_q <= (state_d == StLoad) || (state_d == StPlay);
            done_q    <= (state_d == StDone);
        end
    end

    tone_gen u_tone (
        .clk     (clk),
        .reset   (reset),
        .en      (tone_en),
        .period  (note_q),
        .speaker (speaker)
    );

    assign number  = number_q;
    assign playing = playing_q;
    assign done    = done_q;

endmodule

// File: tb/tb_alarm_player.sv
// Scoreboard bench: three players (one-shot, looping, longer one-shot) share a
// ROM model; expected outputs come from a schedule computed per start offset.
module tb_alarm_player;

    localparam int TICK = 4;
    localparam int NI   = 3;

    typedef logic [8:0] exp_t;  // {number, speaker, playing, done}

    logic clk = 1'b0;
    logic reset, start, stop;

    logic [19:0] rom_note [64];
    logic [4:0]  rom_dur  [64];

    logic [5:0]  num    [NI];
    logic        spk    [NI];
    logic        play   [NI];
    logic        dn     [NI];
    logic [19:0] note_w [NI];
    logic [4:0]  dur_w  [NI];

    exp_t q0[$], q1[$], q2[$];
    bit   run [NI];
    int   t   [NI];
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    alarm_player #(.TICK_CYCLES(TICK), .LAST_INDEX(2), .LOOP(1'b0)) u_once (
        .clk(clk), .reset(reset), .start(start), .stop(stop),
        .note(note_w[0]), .duration(dur_w[0]),
        .number(num[0]), .speaker(spk[0]), .playing(play[0]), .done(dn[0])
    );

    alarm_player #(.TICK_CYCLES(TICK), .LAST_INDEX(1), .LOOP(1'b1)) u_loop (
        .clk(clk), .reset(reset), .start(start), .stop(stop),
        .note(note_w[1]), .duration(dur_w[1]),
        .number(num[1]), .speaker(spk[1]), .playing(play[1]), .done(dn[1])
    );

    alarm_player #(.TICK_CYCLES(TICK), .LAST_INDEX(5), .LOOP(1'b0)) u_long (
        .clk(clk), .reset(reset), .start(start), .stop(stop),
        .note(note_w[2]), .duration(dur_w[2]),
        .number(num[2]), .speaker(spk[2]), .playing(play[2]), .done(dn[2])
    );

    always_comb begin
        for (int k = 0; k < NI; k++) begin
            note_w[k] = rom_note[num[k]];
            dur_w[k]  = rom_dur[num[k]];
        end
    end

    function automatic int last_of(input int k);
        case (k)
            0:       return 2;
            1:       return 1;
            default: return 5;
        endcase
    endfunction

    function automatic bit loop_of(input int k);
        return k == 1;
    endfunction

    // Outputs expected tt cycles after the start edge (tt=0 is the first LOAD).
    function automatic exp_t exp_at(input int k, input int tt);
        int b = 0;
        int idx, d, len, half, p;
        logic s;
        for (int i = 0; i < 4096; i++) begin
            idx = loop_of(k) ? i % (last_of(k) + 1) : i;
            if (!loop_of(k) && idx > last_of(k)) return (tt == b) ? exp_t'(1) : exp_t'(0);
            d   = (rom_dur[idx] == 5'd0) ? 1 : int'(rom_dur[idx]);
            len = 1 + d * TICK;
            if (tt < b + len) begin
                p = tt - b - 1;
                s = 1'b0;
                if (p >= 0 && rom_note[idx] >= 20'd2) begin
                    half = int'(rom_note[idx]) / 2;
                    s = ((p / half) % 2) == 1;
                end
                return {6'(idx), s, 1'b1, 1'b0};
            end
            b += len;
        end
        return '0;
    endfunction

    function automatic void qpush(input int k, input exp_t v);
        case (k)
            0:       q0.push_back(v);
            1:       q1.push_back(v);
            default: q2.push_back(v);
        endcase
    endfunction

    function automatic int qsize(input int k);
        case (k)
            0:       return q0.size();
            1:       return q1.size();
            default: return q2.size();
        endcase
    endfunction

    function automatic exp_t qpop(input int k);
        case (k)
            0:       return q0.pop_front();
            1:       return q1.pop_front();
            default: return q2.pop_front();
        endcase
    endfunction

    // One clock: drive inputs, let the edge happen, push what each DUT should show.
    task automatic step(input logic s, input logic p, input logic r);
        start = s;
        stop  = p;
        reset = r;
        @(posedge clk);
        for (int k = 0; k < NI; k++) begin
            if (r || p) begin
                run[k] = 1'b0;
            end else if (run[k]) begin
                t[k]++;
                if (exp_at(k, t[k]) == '0) run[k] = 1'b0;
            end else if (s) begin
                run[k] = 1'b1;
                t[k]   = 0;
            end
            qpush(k, run[k] ? exp_at(k, t[k]) : exp_t'(0));
        end
        #1;
    endtask

    task automatic run_for(input int n, input bit pokes);
        for (int i = 0; i < n; i++)
            step(pokes && ($urandom_range(0, 15) == 0), 1'b0, 1'b0);
    endtask

    task automatic abort(input bit use_reset);
        if (use_reset) begin
            step(1'b0, 1'b0, 1'b1);
            step(1'b0, 1'b0, 1'b1);
        end else begin
            step(1'b0, 1'b1, 1'b0);
        end
        run_for(3, 1'b0);
    endtask

    task automatic set_rom(input int i, input int n, input int d);
        rom_note[i] = 20'(n);
        rom_dur[i]  = 5'(d);
    endtask

    always @(negedge clk) begin
        exp_t e, a;
        for (int k = 0; k < NI; k++) begin
            if (qsize(k) > 0) begin
                e = qpop(k);
                a = {num[k], spk[k], play[k], dn[k]};
                vectors++;
                if (a !== e) begin
                    miscompares++;
                    $display("FAIL out%0d @%0t num/spk/play/done got %0d/%b/%b/%b want %0d/%b/%b/%b",
                             k, $time, a[8:3], a[2], a[1], a[0], e[8:3], e[2], e[1], e[0]);
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < 64; i++) set_rom(i, 0, 0);
        start = 1'b0;
        stop  = 1'b0;
        reset = 1'b1;
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        run_for(2, 1'b0);

        // Single tone, rest, zero duration, odd period, start during play.
        set_rom(0, 10, 2);
        set_rom(1, 1, 4);
        set_rom(2, 7, 0);
        set_rom(3, 20, 1);
        set_rom(4, 3, 1);
        set_rom(5, 0, 2);
        step(1'b1, 1'b0, 1'b0);
        run_for(4, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        run_for(295, 1'b0);
        abort(1'b0);

        // start and stop together in IDLE.
        step(1'b1, 1'b1, 1'b0);
        run_for(4, 1'b0);

        // Unit-length steps; stop while the long player is at index 3.
        for (int i = 0; i < 6; i++) set_rom(i, 6, 1);
        step(1'b1, 1'b0, 1'b0);
        run_for(16, 1'b0);
        abort(1'b0);

        // Reset mid-play.
        step(1'b1, 1'b0, 1'b0);
        run_for(12, 1'b0);
        abort(1'b1);

        for (int sc = 0; sc < 14; sc++) begin
            for (int i = 0; i < 6; i++) begin
                if ($urandom_range(0, 3) == 0) set_rom(i, int'($urandom_range(0, 1)), 0);
                else set_rom(i, int'($urandom_range(2, 40)), 0);
                rom_dur[i] = 5'($urandom_range(0, 5));
            end
            step(1'b1, ($urandom_range(0, 5) == 0), 1'b0);
            run_for(int'($urandom_range(10, 350)), 1'b1);
            abort($urandom_range(0, 1) == 1);
        end

        run_for(2, 1'b0);
        @(negedge clk);
        #1;
        for (int k = 0; k < NI; k++) begin
            vectors++;
            if (qsize(k) != 0) begin
                miscompares++;
                $display("FAIL drain%0d pending got %0d want 0", k, qsize(k));
            end
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/alarm_player.md
# alarm_player

Sequencer and tone generator directly downstream of the alarm note ROM. It steps the ROM index `number` through the alarm sequence and latches each returned `note` (full period in clock cycles) and `duration` (in tick units). It holds each step for `duration × TICK_CYCLES` cycles while driving a square wave on `speaker`. It then advances, and at the end either wraps or finishes with a `done` pulse.

## Interface
- `TICK_CYCLES`, default 12_500_000: clock cycles per duration unit (1/8 s at 100 MHz).
- `LAST_INDEX`, default 19: final ROM index of the sequence.
- `LOOP`, default 0: 1 wraps to index 0 after `LAST_INDEX`; 0 stops.
- `clk`, input, 1: system clock.
- `reset`, input, 1: reset; synchronous and active-high.
- `start`, input, 1: begin playback; sampled only in IDLE.
- `stop`, input, 1: abort playback; returns to IDLE.
- `note`, input, 20: tone period in clocks from the ROM; values below 2 mean rest.
- `duration`, input, 5: step length in tick units from the ROM.
- `number`, output, 6: ROM index.
- `speaker`, output, 1: square-wave audio output.
- `playing`, output, 1: high in LOAD and PLAY.
- `done`, output, 1: one-cycle pulse at sequence end (only when LOOP=0).

## Operation
- All outputs are registered. Reset gives IDLE, `number`=0, `speaker`=0, `playing`=0, `done`=0, and clears all counters.
- States:
  - IDLE: `number` held at 0. `start` → LOAD.
  - LOAD: one cycle. Latch `note_q`←`note` and `dur_q`←max(`duration`,1); `duration`=0 is treated as 1. Clear the tone, tick and unit counters. Set `speaker`=0. → PLAY.
  - PLAY: `tick_cnt` counts 0..TICK_CYCLES-1. At wrap, `unit_cnt`++. When `unit_cnt` reaches `dur_q`, the step ends:
    - if `number`≠LAST_INDEX: `number`+1 and → LOAD;
    - else if LOOP=1: `number`←0 and → LOAD;
    - else → DONE.
  - DONE: one cycle with `done`=1, `number`←0, `speaker`=0. → IDLE.
- Tone generation in PLAY:
  - `half`=`note_q`>>1.
  - `tone_cnt` counts 0..`half`-1. At `half`-1, toggle `speaker` and clear `tone_cnt`.
  - Period = 2·`half` (odd notes round down).
  - If `note_q`<2 (the ROM rest code is 1), `speaker` is held at 0.
- Priority: `reset` > `stop` > everything else.
  - `stop` in any state → IDLE next cycle, with `number`=0 and `speaker`=0.
  - `start` and `stop` in the same cycle: stop wins.
  - `start` outside IDLE is ignored.
- `number` changes only on the LOAD-entry edge. The ROM is combinational, so its outputs are stable during the LOAD cycle.
- Counter widths: tone counter 19 bits, tick counter $clog2(TICK_CYCLES), unit counter 5 bits. There are no overflows: all comparisons use the latched values.

## Timing
- `start` sampled at edge T:
  - LOAD during cycle T+1 (`number`=0, `playing`=1);
  - PLAY from T+2.
- Each step occupies exactly 1 + `dur_q`·TICK_CYCLES cycles.
- The first `speaker` rise is `half` cycles after PLAY entry.
- `done` rises on the cycle after the last PLAY cycle and lasts exactly one cycle. `playing` is 0 during DONE.
- After the `stop` edge, all outputs reach their reset values on the next cycle.
- Reset in mid-step has the same effect: no partial step resumes.

## Structure
- Shared header/package `alarm_pkg`:
  - state encoding: IDLE, LOAD, PLAY, DONE;
  - `NOTE_REST`=1;
  - duration unit constants (QUARTER=2, HALF=4, ONE=8), shared with the ROM.
- Sub-module `tone_gen`: ports `clk`, `reset`, `en`, `period[19:0]`, `speaker`. It holds the half-period counter and toggle, and owns the rest rule. The player FSM, tick counter and unit counter stay in `alarm_player`.

## Test plan
Every scenario uses TICK_CYCLES=4 and a behavioural ROM model.
1. Reset check: assert `reset` for 2 cycles mid-PLAY → `number`=0, `speaker`=0, `playing`=0, `done`=0 on the next cycle.
2. Single tone: ROM index 0 = {`note`=10, `duration`=2}. Pulse `start` → LOAD at T+1. `speaker` toggles every 5 cycles within PLAY. `number` becomes 1 after exactly 1+8 cycles.
3. Rest handling: `note`=1, `duration`=4 → `speaker` stays 0 for all 16 PLAY cycles. Also `duration`=0 → the step lasts 1+4 cycles.
4. Sequence end with LOOP=0, LAST_INDEX=2, all steps `duration`=1 → `number` goes 0,1,2. `done` is a single-cycle pulse at cycle T+1+3·5. The block is then in IDLE with `number`=0.
5. Looping with LOOP=1, LAST_INDEX=1 → `number` runs 0,1,0,1… with no `done`. `playing` never drops.
6. Abort and contention:
   - `stop` during PLAY at index 3 → IDLE next cycle, `speaker`=0.
   - `start` and `stop` together in IDLE → stays in IDLE.
   - `start` during PLAY → ignored; step timing is unchanged.
